hwpe_stream_fifo_sidech_cnt: RTL and testbench

HWPE_STREAM_FIFO_SIDECH_CNT -- requirements
Module: hwpe_stream_fifo_sidech_cnt

---
 rtl/hwpe_stream_fifo_sidech_cnt_if.sv | 14 +
 rtl/hwpe_stream_fifo_sidech_cnt.sv | 123 ++++++++++++
 tb/tb_hwpe_stream_fifo_sidech_cnt.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_fifo_sidech_cnt_if.sv
// Valid/ready stream bundle carrying a data word plus per-byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_sidech_cnt.sv
// Stream FIFO storing {sidech, data, strb} per entry, with occupancy count and status flags.
// Define HWPE_FIFO_FALLTHROUGH_EN to let an empty FIFO forward push_i straight to pop_o.
module hwpe_stream_fifo_sidech_cnt #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SIDECH_WIDTH = 1,
  parameter int unsigned AFULL_TH     = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_TH    = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  hwpe_stream_intf_stream.sink             push_i,
  hwpe_stream_intf_stream.source           pop_o,
  input  logic [SIDECH_WIDTH-1:0]          sidech_i,
  output logic [SIDECH_WIDTH-1:0]          sidech_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = SIDECH_WIDTH + DATA_WIDTH + STRB_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic               push_ready;
  logic               push_acc;
  logic               pop_valid;
  logic               store;
  logic               pop_mem;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head_raw;
  logic [ENTRY_W-1:0] head;

  assign entry_in   = {sidech_i, push_i.data, push_i.strb};
  assign push_ready = (count_q < CNT_DEPTH);
  assign push_acc   = push_i.valid & push_ready;

`ifdef HWPE_FIFO_FALLTHROUGH_EN
  logic ft_active;
  logic bypass;

  // An empty FIFO presents the incoming word directly; if it is taken, it never touches storage.
  assign ft_active = (count_q == '0);
  assign pop_valid = ~ft_active | push_i.valid;
  assign head_raw  = ft_active ? entry_in : mem_q[rd_ptr_q];
  assign bypass    = ft_active & push_i.valid & pop_o.ready;
  assign store     = push_acc & ~bypass;
  assign pop_mem   = ~ft_active & pop_o.ready;
`else
  assign pop_valid = (count_q != '0);
  assign head_raw  = mem_q[rd_ptr_q];
  assign store     = push_acc;
  assign pop_mem   = pop_valid & pop_o.ready;
`endif

  assign head = pop_valid ? head_raw : '0;

  assign push_i.ready = push_ready;
  assign pop_o.valid  = pop_valid;
  assign pop_o.strb   = head[STRB_W-1:0];
  assign pop_o.data   = head[STRB_W +: DATA_WIDTH];
  assign sidech_o     = head[STRB_W+DATA_WIDTH +: SIDECH_WIDTH];

  assign count_o        = count_q;
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == CNT_DEPTH);
  assign almost_full_o  = (count_q >= CNT_W'(AFULL_TH));
  assign almost_empty_o = (count_q <= CNT_W'(AEMPTY_TH));

  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      mem_d[wr_ptr_q] = entry_in;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_mem) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({store, pop_mem})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over any transfer in the same cycle; stale storage is masked by pop_valid.
    if (clear_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_fifo_sidech_cnt.sv
// Directed self-checking bench: depth-8 instance for fill/flags/sidech/clear/reset,
// depth-5 instance for pointer wrap ordering.
module tb_hwpe_stream_fifo_sidech_cnt;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clearA = 1'b0;
  logic clearB = 1'b0;
  logic [0:0] sidechInA = '0;
  logic [0:0] sidechOutA;
  logic [0:0] sidechInB = '0;
  logic [0:0] sidechOutB;
  logic [3:0] countA;
  logic [2:0] countB;
  logic emptyA, fullA, afullA, aemptyA;
  logic emptyB, fullB, afullB, aemptyB;

  int numAsserts = 0;
  int numFails   = 0;
  int nextPush;
  int expPop;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pushA ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) popA ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pushB ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) popB ();

  always #5 clk_i = ~clk_i;

  hwpe_stream_fifo_sidech_cnt #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .SIDECH_WIDTH(1)) dutA (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clearA),
    .push_i(pushA.sink), .pop_o(popA.source),
    .sidech_i(sidechInA), .sidech_o(sidechOutA), .count_o(countA),
    .empty_o(emptyA), .full_o(fullA), .almost_full_o(afullA), .almost_empty_o(aemptyA)
  );

  hwpe_stream_fifo_sidech_cnt #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .SIDECH_WIDTH(1)) dutB (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clearB),
    .push_i(pushB.sink), .pop_o(popB.source),
    .sidech_i(sidechInB), .sidech_o(sidechOutB), .count_o(countB),
    .empty_o(emptyB), .full_o(fullB), .almost_full_o(afullB), .almost_empty_o(aemptyB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numAsserts++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic [3:0] strb,
                               input logic sidech, input logic ready);
    pushA.valid = valid;
    pushA.data  = data;
    pushA.strb  = strb;
    sidechInA   = sidech;
    popA.ready  = ready;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    pushB.valid = 1'b0; pushB.data = '0; pushB.strb = 4'hF; popB.ready = 1'b0;

    #12;
    checkOutput("rstCount", countA, 0);
    checkOutput("rstEmpty", emptyA, 1);
    checkOutput("rstAEmpty", aemptyA, 1);
    checkOutput("rstFull", fullA, 0);
    checkOutput("rstAFull", afullA, 0);
    checkOutput("rstPopValid", popA.valid, 0);
    checkOutput("rstPushReady", pushA.ready, 1);
    checkOutput("rstPopData", popA.data, 0);
    stepClock();
    rst_ni = 1'b1;
    stepClock();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h10 + i, 4'hF, 1'b0, 1'b0);
      stepClock();
      checkOutput("fillCount", countA, i + 1);
      checkOutput("fillAFull", afullA, (i + 1 >= 6) ? 1 : 0);
      checkOutput("fillFull", fullA, (i == 7) ? 1 : 0);
    end
    checkOutput("fullPushReady", pushA.ready, 0);
    checkOutput("fullAEmpty", aemptyA, 0);
    applyStimulus(1'b1, 32'h99, 4'hF, 1'b0, 1'b0);
    stepClock();
    checkOutput("fullNoPushCount", countA, 8);
    checkOutput("fullHead", popA.data, 32'h10);
    applyStimulus(1'b1, 32'h99, 4'hF, 1'b0, 1'b1);
    #1;
    checkOutput("fullPushPopHead", popA.data, 32'h10);
    stepClock();
    checkOutput("fullPushPopCount", countA, 7);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      #1;
      checkOutput("drainValid", popA.valid, 1);
      checkOutput("drainData", popA.data, 32'h10 + i);
      stepClock();
    end
    checkOutput("drainCount", countA, 0);
    checkOutput("drainEmpty", emptyA, 1);
    checkOutput("drainPopValid", popA.valid, 0);
    checkOutput("drainPopData", popA.data, 0);

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, i, 4'hF, 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("simPreCount", countA, 3);
    applyStimulus(1'b1, 32'hAA, 4'hF, 1'b0, 1'b1);
    #1;
    checkOutput("simPopOldest", popA.data, 32'h1);
    stepClock();
    checkOutput("simCount", countA, 3);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    checkOutput("simPop2", popA.data, 32'h2);
    stepClock();
    checkOutput("simPop3", popA.data, 32'h3);
    stepClock();
    checkOutput("simPopAA", popA.data, 32'hAA);
    stepClock();
    checkOutput("simEndCount", countA, 0);

    applyStimulus(1'b1, 32'h55, 4'hA, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h66, 4'hF, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("sideData55", popA.data, 32'h55);
    checkOutput("sideSide55", sidechOutA, 1);
    checkOutput("sideStrb55", popA.strb, 4'hA);
    popA.ready = 1'b1;
    stepClock();
    checkOutput("sideData66", popA.data, 32'h66);
    checkOutput("sideSide66", sidechOutA, 0);
    stepClock();
    checkOutput("sideEmptySide", sidechOutA, 0);
    checkOutput("sideEmptyValid", popA.valid, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h21 + i, 4'hF, 1'b1, 1'b0);
      stepClock();
    end
    checkOutput("clrPreCount", countA, 4);
    applyStimulus(1'b1, 32'h25, 4'hF, 1'b1, 1'b0);
    clearA = 1'b1;
    stepClock();
    clearA = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("clrCount", countA, 0);
    checkOutput("clrEmpty", emptyA, 1);
    checkOutput("clrPopValid", popA.valid, 0);
    checkOutput("clrPopData", popA.data, 0);
    checkOutput("clrSide", sidechOutA, 0);
    applyStimulus(1'b1, 32'h31, 4'hF, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("clrFirstAfter", popA.data, 32'h31);
    checkOutput("clrFirstCount", countA, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h41 + i, 4'hF, 1'b1, 1'b0);
      stepClock();
    end
    checkOutput("rst2PreCount", countA, 4);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst2Count", countA, 0);
    checkOutput("rst2Empty", emptyA, 1);
    checkOutput("rst2PopData", popA.data, 0);
    checkOutput("rst2Side", sidechOutA, 0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    stepClock();
    applyStimulus(1'b1, 32'h51, 4'hF, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rst2FirstAfter", popA.data, 32'h51);
    popA.ready = 1'b1;
    stepClock();
    checkOutput("rst2Drained", countA, 0);

    applyStimulus(1'b1, 32'h77, 4'hF, 1'b0, 1'b1);
    #1;
`ifdef HWPE_FIFO_FALLTHROUGH_EN
    checkOutput("ftSameValid", popA.valid, 1);
    checkOutput("ftSameData", popA.data, 32'h77);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    checkOutput("ftCount", countA, 0);
    checkOutput("ftAfterValid", popA.valid, 0);
`else
    checkOutput("regSameValid", popA.valid, 0);
    checkOutput("regSameData", popA.data, 0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    checkOutput("regNextCount", countA, 1);
    checkOutput("regNextData", popA.data, 32'h77);
    stepClock();
    checkOutput("regDrained", countA, 0);
`endif

    nextPush = 0;
    expPop   = 0;
    for (int k = 0; k < 80 && expPop < 12; k++) begin
      pushB.valid = (nextPush < 12);
      pushB.data  = nextPush;
      popB.ready  = (k % 3 != 0);
      #1;
      if (popB.valid && popB.ready) begin
        checkOutput("wrapOrder", popB.data, expPop);
        expPop++;
      end
      if (pushB.valid && pushB.ready) nextPush++;
      stepClock();
    end
    pushB.valid = 1'b0;
    popB.ready  = 1'b0;
    #1;
    checkOutput("wrapAllPopped", expPop, 12);
    checkOutput("wrapAllPushed", nextPush, 12);
    checkOutput("wrapCount", countB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
